regfile_writeback_arbiter: RTL and testbench
============================================

Name: regfile_writeback_arbiter

Overview:
- Write-side front end for the dual-bank (integer/float) register file.
- Accepts integer-pipe results directly and buffers FPU results in a small FIFO.
- Merges both streams onto the file's single write port: write index, write data, write enable, bank select.
- Outputs are registered so the register file samples them on the following rising edge.

Parameters:
- FQ_DEPTH, 4, float result queue entries (power of 2, >=2)
- STARVE_LIM, 8, cycles a float queue head may wait before a forced drain (>=1)
- REG_AW, 6, register index width (matches register file address ports)
- DATA_W, 32, result data width

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- int_valid  in  1  integer result offered
- int_ready  out  1  integer result accepted this cycle (combinational from registered state)
- int_reg  in  REG_AW  integer destination index
- int_data  in  DATA_W  integer result
- fp_valid  in  1  float result offered
- fp_ready  out  1  float queue has space (= !full)
- fp_reg  in  REG_AW  float destination index
- fp_data  in  DATA_W  float result
- writeReg  out  REG_AW  register file write index
- writeData  out  DATA_W  register file write data
- regWrite  out  1  register file write enable, one-cycle pulse per write
- float  out  1  bank select: 1 = float bank, 0 = integer bank
- fq_count  out  clog2(FQ_DEPTH)+1  float queue occupancy
- fp_pending  out  1  fq_count != 0

Behaviour:
- Reset (async, rst_n low): writeReg=0, writeData=0, regWrite=0, float=0, queue empty (fq_count=0), starve counter=0. Any in-flight entries are discarded.
- Float enqueue: on a rising edge with fp_valid & fp_ready, push {fp_reg, fp_data}. fp_ready depends only on the registered count, so a pop in the same cycle does not free the slot until the next cycle.
- Arbitration, evaluated once per cycle from registered state:
  - force = (fq_count==FQ_DEPTH) | (fq_count!=0 & starve_cnt>=STARVE_LIM)
  - if force: pop float head; int_ready=0
  - else if int_valid: int_ready=1; write the integer result
  - else if fq_count!=0: pop float head
  - else: no write
- int_ready is 1 whenever force=0, regardless of int_valid.
- Output register on the rising edge:
  - integer win: writeReg=int_reg, writeData=int_data, float=0, regWrite=1
  - float pop: head fields, float=1, regWrite=1
  - no write: regWrite=0; writeReg, writeData and float hold their previous values
- Latency:
  - integer: accepted at edge N, regWrite high for cycle N..N+1
  - float: minimum 2 edges (enqueue, then pop)
- Starve counter:
  - clears when the queue is empty or when a pop occurs
  - otherwise increments by 1 each cycle the head waits, saturating at STARVE_LIM
- Simultaneous push and pop: count unchanged; pointers both advance, modulo FQ_DEPTH.
- Order:
  - float results retire in FIFO order
  - integer vs float ordering is not preserved; the banks are disjoint, so there is no hazard
- Push while full: cannot occur when the protocol is obeyed (fp_ready=0). An illegal push is ignored with no state change.

Optional Feature:
- Macro: WB_ZERO_GUARD_EN.
- Defined: an integer result with int_reg==0 is still accepted (int_ready follows the normal rule) but produces regWrite=0. This enforces the hardwired-zero integer register. Float index 0 is unaffected.
- Undefined: integer index 0 is written like any other index.

Test Plan:
- Reset mid-stream:
  - stimulus: queue 3 float entries, assert rst_n=0 asynchronously between edges
  - response: regWrite, fq_count and writeReg go to 0 immediately; no write after release
- Integer only:
  - stimulus: int_valid=1, int_reg=5, int_data=32'hDEADBEEF at edge N
  - response: cycle N+1 shows regWrite=1, float=0, writeReg=5, writeData=DEADBEEF; the next cycle with int_valid=0 shows regWrite=0
- Float FIFO order:
  - stimulus: push fp regs 1,2,3 (data 0x3F800000, 0x40000000, 0x40400000) with int_valid=0
  - response: three consecutive float=1 writes in order 1,2,3; fp_pending falls after the last pop
- Full forces drain:
  - stimulus: hold int_valid=1 continuously, push 4 float entries
  - response: when fq_count=4, int_ready=0 for exactly one cycle, a float write occurs, then integer writes resume
- Starvation limit:
  - stimulus: STARVE_LIM=8, one float entry queued, int_valid held 1
  - response: the float entry is written once it has waited 8 cycles; int_ready=0 in that cycle only
- Zero guard:
  - stimulus: with WB_ZERO_GUARD_EN defined, int_reg=0, int_valid=1
  - response: int_ready=1, regWrite stays 0
  - without the macro: regWrite=1, writeReg=0

Source files
------------

// File: rtl/regfile_writeback_arbiter.sv
// Register file write-port arbiter: integer results pass through, FPU results queue.
// Optional macro WB_ZERO_GUARD_EN suppresses integer writes to index 0.
module regfile_writeback_arbiter #(
  parameter int FQ_DEPTH   = 4,
  parameter int STARVE_LIM = 8,
  parameter int REG_AW     = 6,
  parameter int DATA_W     = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      int_valid,
  output logic                      int_ready,
  input  logic [REG_AW-1:0]         int_reg,
  input  logic [DATA_W-1:0]         int_data,
  input  logic                      fp_valid,
  output logic                      fp_ready,
  input  logic [REG_AW-1:0]         fp_reg,
  input  logic [DATA_W-1:0]         fp_data,
  output logic [REG_AW-1:0]         writeReg,
  output logic [DATA_W-1:0]         writeData,
  output logic                      regWrite,
  output logic                      float,
  output logic [$clog2(FQ_DEPTH):0] fq_count,
  output logic                      fp_pending
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0] FULL_C = CW'(FQ_DEPTH);
  localparam logic [SW-1:0] LIM_C  = SW'(STARVE_LIM);

  typedef struct packed {
    logic [REG_AW-1:0] idx;
    logic [DATA_W-1:0] data;
  } fq_ent_t;

  fq_ent_t           mem_q [FQ_DEPTH];
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [REG_AW-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              flt_q, flt_d;

  logic full, force_pop, pop, push;
  logic int_win, int_wr, not_empty;

  always_comb begin
    not_empty = cnt_q != '0;
    full      = cnt_q == FULL_C;
    force_pop = full | (not_empty & (starve_q >= LIM_C));
    pop       = force_pop | (!int_valid & not_empty);
    int_win   = !force_pop & int_valid;
    push      = fp_valid & !full;
`ifdef WB_ZERO_GUARD_EN
    int_wr    = int_win & (int_reg != '0);
`else
    int_wr    = int_win;
`endif

    wr_d  = push ? wr_q + PW'(1) : wr_q;
    rd_d  = pop  ? rd_q + PW'(1) : rd_q;
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // Head age: only counts while an entry sits unserved
    starve_d = starve_q;
    if (!not_empty || pop)
      starve_d = '0;
    else if (starve_q < LIM_C)
      starve_d = starve_q + SW'(1);

    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    flt_d   = flt_q;
    we_d    = pop | int_wr;
    if (pop) begin
      wreg_d  = mem_q[rd_q].idx;
      wdata_d = mem_q[rd_q].data;
      flt_d   = 1'b1;
    end else if (int_wr) begin
      wreg_d  = int_reg;
      wdata_d = int_data;
      flt_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_q] <= '{idx: fp_reg, data: fp_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      wreg_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      flt_q    <= 1'b0;
    end else begin
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      flt_q    <= flt_d;
    end
  end

  assign int_ready  = !force_pop;
  assign fp_ready   = !full;
  assign fq_count   = cnt_q;
  assign fp_pending = not_empty;
  assign writeReg   = wreg_q;
  assign writeData  = wdata_q;
  assign regWrite   = we_q;
  assign float      = flt_q;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Scoreboard bench for regfile_writeback_arbiter.
// Honours WB_ZERO_GUARD_EN to match the DUT build.
module tb_regfile_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        int_valid = 1'b0;
  logic        int_ready;
  logic [5:0]  int_reg = '0;
  logic [31:0] int_data = '0;
  logic        fp_valid = 1'b0;
  logic        fp_ready;
  logic [5:0]  fp_reg = '0;
  logic [31:0] fp_data = '0;
  logic [5:0]  writeReg;
  logic [31:0] writeData;
  logic        regWrite;
  logic        float;
  logic [2:0]  fq_count;
  logic        fp_pending;

  regfile_writeback_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .int_valid(int_valid), .int_ready(int_ready),
    .int_reg(int_reg), .int_data(int_data),
    .fp_valid(fp_valid), .fp_ready(fp_ready),
    .fp_reg(fp_reg), .fp_data(fp_data),
    .writeReg(writeReg), .writeData(writeData),
    .regWrite(regWrite), .float(float),
    .fq_count(fq_count), .fp_pending(fp_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  r;
    logic [31:0] d;
  } exp_t;

  exp_t iq[$];
  exp_t fq[$];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic flag(input string name);
    n_checks++;
    $display("FAIL %s: got write with regWrite=1 expected none", name);
  endtask

  // Monitor: every write must match the head of its bank's queue
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && regWrite) begin
      if (float) begin
        if (fq.size() == 0) flag("fp_unexpected");
        else begin
          e = fq.pop_front();
          chk("fp_reg", writeReg, e.r);
          chk("fp_data", writeData, e.d);
        end
      end else begin
        if (iq.size() == 0) flag("int_unexpected");
        else begin
          e = iq.pop_front();
          chk("int_reg", writeReg, e.r);
          chk("int_data", writeData, e.d);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drv_int(input logic v, input logic [5:0] r,
                         input logic [31:0] d);
    int_valid = v;
    int_reg   = r;
    int_data  = d;
    if (v && int_ready) begin
`ifdef WB_ZERO_GUARD_EN
      if (r != 6'd0) iq.push_back('{r: r, d: d});
`else
      iq.push_back('{r: r, d: d});
`endif
    end
  endtask

  task automatic drv_fp(input logic v, input logic [5:0] r,
                        input logic [31:0] d);
    fp_valid = v;
    fp_reg   = r;
    fp_data  = d;
    if (v && fp_ready) fq.push_back('{r: r, d: d});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k, zeros, first;

    repeat (2) tick();
    chk("rst_we", regWrite, 0);
    chk("rst_wreg", writeReg, 0);
    chk("rst_wdata", writeData, 0);
    chk("rst_float", float, 0);
    chk("rst_count", fq_count, 0);
    chk("rst_pend", fp_pending, 0);
    chk("rst_int_ready", int_ready, 1);
    chk("rst_fp_ready", fp_ready, 1);
    rst_n = 1'b1;

    // Integer only
    tick();
    drv_int(1, 6'd5, 32'hDEADBEEF);
    chk("int_ready", int_ready, 1);
    tick();
    drv_int(0, 6'd0, 32'h0);
    chk("int_we", regWrite, 1);
    chk("int_bank", float, 0);
    chk("int_wreg", writeReg, 5);
    tick();
    chk("int_we_idle", regWrite, 0);

    // Float FIFO order
    tick();
    drv_fp(1, 6'd1, 32'h3F800000);
    tick();
    drv_fp(1, 6'd2, 32'h40000000);
    chk("fp_count1", fq_count, 1);
    tick();
    drv_fp(1, 6'd3, 32'h40400000);
    chk("fp_w1", {regWrite, float, writeReg}, {2'b11, 6'd1});
    tick();
    drv_fp(0, 6'd0, 32'h0);
    chk("fp_w2", {regWrite, float, writeReg}, {2'b11, 6'd2});
    tick();
    chk("fp_w3", {regWrite, float, writeReg}, {2'b11, 6'd3});
    chk("fp_pend_fall", fp_pending, 0);
    tick();
    chk("fp_idle", regWrite, 0);

    // Full queue forces one drain while integers stream
    k = 0;
    zeros = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i < 4) drv_fp(1, 6'(10 + i), 32'hF0000000 + 32'(i));
      else drv_fp(0, 6'd0, 32'h0);
      drv_int(1, 6'(20 + k), 32'h1000 + 32'(k));
      if (int_ready) k++;
      else zeros++;
      if (i == 4) begin
        chk("full_count", fq_count, 4);
        chk("full_int_ready", int_ready, 0);
        chk("full_fp_ready", fp_ready, 0);
      end
      if (i == 5) begin
        chk("full_drain", {regWrite, float}, 2'b11);
        chk("full_int_resume", int_ready, 1);
      end
      if (i == 6) chk("full_int_write", {regWrite, float}, 2'b10);
    end
    chk("full_stall_cycles", zeros, 1);
    tick();
    drv_int(0, 6'd0, 32'h0);
    for (int t = 0; t < 20 && fp_pending; t++) tick();
    chk("full_drain_done", fp_pending, 0);
    repeat (2) tick();

    // Starvation limit
    tick();
    drv_fp(1, 6'd7, 32'h40800000);
    drv_int(1, 6'd30, 32'hA0);
    first = -1;
    zeros = 0;
    for (int i = 1; i < 12; i++) begin
      tick();
      if (i == 1) drv_fp(0, 6'd0, 32'h0);
      drv_int(1, 6'(30 + i), 32'hA0 + 32'(i));
      if (!int_ready) begin
        zeros++;
        if (first < 0) first = i;
      end
      if (i == 10) chk("starve_write", {regWrite, float, writeReg}, {2'b11, 6'd7});
    end
    chk("starve_first", first, 9);
    chk("starve_stall_cycles", zeros, 1);
    tick();
    drv_int(0, 6'd0, 32'h0);
    repeat (2) tick();

    // Integer index 0
    tick();
    drv_int(1, 6'd0, 32'h1234);
    chk("zero_int_ready", int_ready, 1);
    tick();
    drv_int(0, 6'd0, 32'h0);
`ifdef WB_ZERO_GUARD_EN
    chk("zero_guard_we", regWrite, 0);
`else
    chk("zero_we", regWrite, 1);
    chk("zero_wreg", writeReg, 0);
`endif
    tick();

    // Reset mid-stream with queued float entries
    for (int i = 0; i < 3; i++) begin
      tick();
      drv_int(1, 6'd9, 32'h900 + 32'(i));
      drv_fp(1, 6'(40 + i), 32'hC0000000 + 32'(i));
    end
    tick();
    drv_int(0, 6'd0, 32'h0);
    drv_fp(0, 6'd0, 32'h0);
    chk("mid_count", fq_count, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_we", regWrite, 0);
    chk("mid_rst_count", fq_count, 0);
    chk("mid_rst_wreg", writeReg, 0);
    fq.delete();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_post_we", regWrite, 0);
    end
    chk("mid_post_count", fq_count, 0);

    chk("iq_empty", iq.size(), 0);
    chk("fq_empty", fq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
